// File: rtl/ov5640_frame_dma_ctrl.sv
// ov5640_frame_dma_ctrl: drains the OV5640 capture store into DDR as AXI4
// INCR write bursts, rotating frames through three buffers while never
// overwriting the buffer the display is reading.
// Optional statistics counters (frame/abort/error) when CAM_DMA_STATS_EN is defined.
module ov5640_frame_dma_ctrl #(
  parameter int          ADDR_W       = 32,
  parameter int          BURST_LEN    = 256,
  parameter logic [31:0] FRAME_STRIDE = 32'h0020_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_on,
  input  logic [15:0]       expect_width,
  input  logic [15:0]       expect_height,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              store_almost_empty,
  input  logic [31:0]       store_rd_data,
  output logic              store_rd_data_en,
  input  logic [1:0]        disp_buf_idx,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        done_buf_idx,
  output logic              done_valid,
  output logic              frame_done,
  output logic              wr_err,
  output logic              busy
`ifdef CAM_DMA_STATS_EN
  ,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       abort_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t state, state_nxt;

  logic [31:0]       word_cnt, frame_words, fw_eff, remaining, burst_words, cnt_sum;
  logic [BW-1:0]     len_nxt;
  logic [7:0]        beat_cnt;
  logic [7:0]        awlen_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic              abort_q, abort_now, go, b_hs, frame_end;
  logic [1:0]        next_buf;

  // Frame size is re-evaluated only at a frame boundary so a mid-frame
  // change of the expected geometry cannot corrupt the running count.
  assign fw_eff      = (word_cnt == 32'd0) ? ((32'(expect_width) * 32'(expect_height)) >> 1)
                                           : frame_words;
  assign remaining   = fw_eff - word_cnt;
  assign len_nxt     = (remaining < 32'(BURST_LEN)) ? remaining[BW-1:0] : BW'(BURST_LEN);
  assign go          = capture_on && !store_almost_empty && (fw_eff != 32'd0) && (word_cnt < fw_eff);
  assign burst_words = 32'(awlen_q) + 32'd1;
  assign cnt_sum     = word_cnt + burst_words;
  assign b_hs        = (state == B) && m_axi_bvalid;
  assign frame_end   = b_hs && !abort_q && (cnt_sum == frame_words);
  // Once capture drops, the rest of the burst is padding even before the flag registers.
  assign abort_now   = abort_q | ~capture_on;

  assign m_axi_awaddr = awaddr_q;
  assign m_axi_awlen  = awlen_q;
  assign m_axi_wdata  = store_rd_data;

  // Next buffer: lowest index not being written and not being displayed (3 = no display).
  always_comb begin
    next_buf = 2'd0;
    for (int i = 2; i >= 0; i--)
      if (2'(i) != wr_buf_idx && 2'(i) != disp_buf_idx) next_buf = 2'(i);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and AXI/store handshake outputs.
  always_comb begin
    state_nxt        = state;
    m_axi_awvalid    = 1'b0;
    m_axi_wvalid     = 1'b0;
    m_axi_wlast      = 1'b0;
    m_axi_wstrb      = 4'h0;
    m_axi_bready     = 1'b0;
    store_rd_data_en = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE: if (go) state_nxt = AW;
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = W;
      end
      W: begin
        m_axi_wvalid     = 1'b1;
        m_axi_wlast      = (beat_cnt == awlen_q);
        m_axi_wstrb      = abort_now ? 4'h0 : 4'hF;
        store_rd_data_en = m_axi_wready & ~abort_now;
        if (m_axi_wready && m_axi_wlast) state_nxt = B;
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst setup, beat counting, frame accounting and buffer rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt     <= '0;
      frame_words  <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      beat_cnt     <= '0;
      abort_q      <= 1'b0;
      wr_buf_idx   <= 2'd0;
      done_buf_idx <= 2'd0;
      done_valid   <= 1'b0;
      frame_done   <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!capture_on) word_cnt <= '0;
          if (word_cnt == 32'd0) frame_words <= fw_eff;
          if (go) begin
            awaddr_q <= frame_base + ADDR_W'(wr_buf_idx) * ADDR_W'(FRAME_STRIDE)
                        + ADDR_W'({word_cnt, 2'b00});
            awlen_q  <= 8'(len_nxt - BW'(1));
          end
        end
        AW: begin
          if (!capture_on) abort_q <= 1'b1;
          if (m_axi_awready) beat_cnt <= '0;
        end
        W: begin
          if (!capture_on) abort_q <= 1'b1;
          if (m_axi_wready) beat_cnt <= beat_cnt + 8'd1;
        end
        B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) wr_err <= 1'b1;
            if (abort_q) begin
              word_cnt <= '0;
              abort_q  <= 1'b0;
            end else if (cnt_sum == frame_words) begin
              frame_done   <= 1'b1;
              done_buf_idx <= wr_buf_idx;
              done_valid   <= 1'b1;
              word_cnt     <= '0;
              wr_buf_idx   <= next_buf;
            end else begin
              word_cnt <= cnt_sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CAM_DMA_STATS_EN
  // Completed frames wrap; aborted bursts and error responses saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 32'd1;
      if (b_hs && abort_q && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
      if (b_hs && m_axi_bresp != 2'b00 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ov5640_frame_dma_ctrl.md
Name: ov5640_frame_dma_ctrl

Overview:
Write-side DMA controller between the OV5640 capture store, which provides 32-bit words behind an almost_empty/rd_data_en interface, and an AXI4 write master port to DDR. It packs store words into INCR bursts and tracks the word count of each frame. Frames rotate through three frame buffers, and the buffer currently being displayed is never overwritten. Each completed frame is reported to the display/readout side.

Parameters:
ADDR_W, 32, AXI address width
BURST_LEN, 256, maximum beats per burst; the store's almost_empty threshold guarantees at least BURST_LEN words when low
FRAME_STRIDE, 32'h0020_0000, byte distance between buffer bases; multiple of 4096

Ports:
clk  in  1  system clock (same clock as the store read side)
rst  in  1  reset; asynchronous, active-high
capture_on  in  1  capture enable (same signal the store uses)
expect_width  in  16  pixels per line
expect_height  in  16  lines per frame
frame_base  in  ADDR_W  byte address of buffer 0; 4 KB aligned
store_almost_empty  in  1  store has fewer than BURST_LEN words
store_rd_data  in  32  store head word, valid while the store is not empty
store_rd_data_en  out  1  pop the store head word
disp_buf_idx  in  2  buffer index the display is reading; values 0..2
m_axi_awaddr  out  ADDR_W
m_axi_awlen  out  8
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  32
m_axi_wstrb  out  4
m_axi_wlast  out  1
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
wr_buf_idx  out  2  buffer being written
done_buf_idx  out  2  most recently completed buffer
done_valid  out  1  done_buf_idx holds a complete frame (sticky)
frame_done  out  1  one-cycle pulse when a frame completes
wr_err  out  1  sticky flag set by a non-OKAY bresp; cleared only by rst
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - All AXI valid/ready/last outputs, awaddr, awlen, wstrb and store_rd_data_en are 0.
  - wr_buf_idx=0, done_buf_idx=0, done_valid=0, frame_done=0, wr_err=0.
  - word_cnt=0, frame_words=0.
- frame_words: latched in IDLE as (expect_width*expect_height)>>1 (32-bit product; RGB565, two pixels per word).
  - Latched only when word_cnt==0.
  - If frame_words==0, the block never leaves IDLE.
- Sign convention: remaining = frame_words - word_cnt; len = min(BURST_LEN, remaining).
- IDLE:
  - capture_on low: word_cnt <= 0; stay in IDLE.
  - capture_on high and store_almost_empty low: go to AW with:
    - awaddr = frame_base + wr_buf_idx*FRAME_STRIDE + word_cnt*4;
    - awlen = len-1.
- AW:
  - awvalid is held high with stable awaddr/awlen until awready.
  - After the handshake, go to W with beat counter = 0.
- W:
  - wvalid=1, wdata=store_rd_data (combinational), wstrb=4'hF.
  - store_rd_data_en = wvalid & wready, so one word is popped per accepted beat.
  - wlast is high on beat len-1.
  - After the wlast handshake, go to B.
- Abort: if capture_on falls during AW or W, the burst still completes, because AXI cannot abort.
  - Remaining beats are sent with wstrb=0 and store_rd_data_en=0.
  - An abort flag is set.
- B: bready=1. On bvalid:
  - If bresp!=0, set wr_err.
  - If the abort flag is set: word_cnt <= 0, clear the abort flag, go to IDLE.
  - Otherwise word_cnt += len.
  - If the new word_cnt equals frame_words:
    - frame_done pulses one cycle;
    - done_buf_idx <= wr_buf_idx, done_valid <= 1;
    - word_cnt <= 0;
    - wr_buf_idx <= lowest index in {0,1,2} that differs from both the current wr_buf_idx and disp_buf_idx (sampled this cycle).
  - Go to IDLE.
- Timing: minimum one IDLE cycle between bursts. At most one outstanding burst, with no address/data overlap.
- A partial last burst (remaining < BURST_LEN) still waits for store_almost_empty low.
- disp_buf_idx==3 is treated as "none"; the next buffer is then the lowest index other than wr_buf_idx.
- Mid-operation reset: all state is cleared immediately. The AXI slave is reset together with this block.

Optional Feature:
Macro CAM_DMA_STATS_EN.
- When defined, three extra ports are added:
  - frame_cnt  out 32: completed frames, wrapping;
  - abort_cnt  out 16: aborted bursts, saturating at 16'hFFFF;
  - err_cnt  out 16: non-OKAY bresp count, saturating.
- All three counters are 0 on reset.
- When undefined, these ports and counters do not exist; other behaviour is identical.

Test Plan:
1. Frame completion: width=16, height=32, BURST_LEN=256 (frame_words=256), store almost_empty low, awready/wready/bvalid always 1 -> one burst, awaddr=frame_base, awlen=255, 256 pops, frame_done pulse, done_buf_idx=0, wr_buf_idx=1.
2. Buffer rotation: width=1280, height=720 (460800 words = 1800 bursts, all full), disp_buf_idx=1 -> buffer sequence 0->2->0; buffer 1 is never written; frame 2 first awaddr = frame_base+2*FRAME_STRIDE.
3. Partial last burst: width=20, height=30 (300 words) -> bursts awlen=255 then awlen=43; second awaddr = base+1024; frame_done after the second bresp.
4. Backpressure: wready toggles every cycle and awready is delayed 5 cycles -> exactly 256 store pops, wlast only on the last accepted beat, awaddr stable while awvalid is high.
5. Abort: capture_on drops at beat 100 -> beats 100..255 carry wstrb=0 with no pops; after bresp, word_cnt=0 and no frame_done; next capture restarts at the buffer base.
6. Error: bresp=2'b10 on the first burst -> wr_err=1 and stays 1; the frame still completes; err_cnt=1 when CAM_DMA_STATS_EN is defined.
